// File: rtl/aes_decrypt_iter.sv
// Iterative AES-128 decryptor. One round per falling clock edge. The key schedule
// is cached and is reused when the same cipher key is presented again.
package aes_gf_pkg;
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, t;
    p = 8'h00;
    t = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ t;
      t = xtime(t);
    end
    return p;
  endfunction

  // Computes a^254, which is the multiplicative inverse. The value 0 maps to 0.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240;
    x2   = gmul(a, a);
    x3   = gmul(x2, a);
    x6   = gmul(x3, x3);
    x12  = gmul(x6, x6);
    x15  = gmul(x12, x3);
    x30  = gmul(x15, x15);
    x60  = gmul(x30, x30);
    x120 = gmul(x60, x60);
    x240 = gmul(x120, x120);
    return gmul(gmul(x240, x12), x2);
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] v;
    v = gf_inv(a);
    return v ^ rotl(v, 1) ^ rotl(v, 2) ^ rotl(v, 3) ^ rotl(v, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] a);
    return gf_inv(rotl(a, 1) ^ rotl(a, 3) ^ rotl(a, 6) ^ 8'h05);
  endfunction
endpackage

module aes_inv_sbox
  import aes_gf_pkg::*;
(
  input  logic [7:0] a,
  output logic [7:0] y
);
  assign y = inv_sbox(a);
endmodule

module aes_sbox
  import aes_gf_pkg::*;
(
  input  logic [7:0] a,
  output logic [7:0] y
);
  assign y = sbox(a);
endmodule

module aes_decrypt_iter
  import aes_gf_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] data_in,
  input  logic [127:0] key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] plaintext,
  output logic         busy
);
  typedef enum logic [2:0] {IDLE, KEXP, INIT, ROUND, FINAL, HOLD} state_t;

  state_t       fsm;
  logic [127:0] ct, st;
  logic [127:0] rk [0:10];
  logic         keys_ok;
  logic [3:0]   cnt, rnd;
  logic         accept;

  assign accept = (fsm == IDLE) && in_ready && in_valid;

  // Shared InvShiftRows + InvSubBytes front end. Bytes are numbered column-major,
  // with byte 0 in the most significant bits.
  logic [127:0] isr, isb, ark, imc;
  for (genvar i = 0; i < 16; i++) begin : g_lane
    localparam int C   = i / 4;
    localparam int R   = i % 4;
    localparam int SRC = ((C - R + 4) % 4) * 4 + R;
    assign isr[127-8*i -: 8] = st[127-8*SRC -: 8];
    aes_inv_sbox u_isb (.a(isr[127-8*i -: 8]), .y(isb[127-8*i -: 8]));
  end

  assign ark = isb ^ rk[rnd];

  for (genvar c = 0; c < 4; c++) begin : g_col
    logic [7:0] a0, a1, a2, a3;
    assign a0 = ark[127-32*c -: 8];
    assign a1 = ark[119-32*c -: 8];
    assign a2 = ark[111-32*c -: 8];
    assign a3 = ark[103-32*c -: 8];
    assign imc[127-32*c -: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
    assign imc[119-32*c -: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
    assign imc[111-32*c -: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
    assign imc[103-32*c -: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
  end

  // Forward key expansion: produces one round key per cycle from rk[cnt-1].
  logic [3:0]   prev_idx;
  logic [127:0] rk_prev, rk_next;
  logic [31:0]  rot, sub, t, w0, w1, w2, w3;
  logic [7:0]   rcon;

  assign prev_idx = (cnt == 4'd0) ? 4'd0 : cnt - 4'd1;
  assign rk_prev  = rk[prev_idx];
  assign rot      = {rk_prev[23:0], rk_prev[31:24]};

  for (genvar j = 0; j < 4; j++) begin : g_ksb
    aes_sbox u_sb (.a(rot[31-8*j -: 8]), .y(sub[31-8*j -: 8]));
  end

  always_comb begin
    rcon = 8'h00;
    case (cnt)
      4'd1:  rcon = 8'h01;
      4'd2:  rcon = 8'h02;
      4'd3:  rcon = 8'h04;
      4'd4:  rcon = 8'h08;
      4'd5:  rcon = 8'h10;
      4'd6:  rcon = 8'h20;
      4'd7:  rcon = 8'h40;
      4'd8:  rcon = 8'h80;
      4'd9:  rcon = 8'h1b;
      4'd10: rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  end

  assign t       = sub ^ {rcon, 24'h0};
  assign w0      = rk_prev[127:96] ^ t;
  assign w1      = rk_prev[95:64] ^ w0;
  assign w2      = rk_prev[63:32] ^ w1;
  assign w3      = rk_prev[31:0] ^ w2;
  assign rk_next = {w0, w1, w2, w3};

  // The round-key file needs no reset. keys_ok tracks whether its contents are valid.
  always_ff @(negedge clk) begin
    if (accept) rk[0] <= key;
    else if (fsm == KEXP) rk[cnt] <= rk_next;
  end

  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      fsm       <= IDLE;
      in_ready  <= 1'b0;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      plaintext <= '0;
      keys_ok   <= 1'b0;
      cnt       <= 4'd0;
      rnd       <= 4'd0;
      st        <= '0;
      ct        <= '0;
    end else begin
      case (fsm)
        IDLE: begin
          in_ready <= 1'b1;
          busy     <= 1'b0;
          if (accept) begin
            ct       <= data_in;
            cnt      <= 4'd1;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            if (keys_ok && key == rk[0]) fsm <= INIT;
            else begin
              keys_ok <= 1'b0;
              fsm     <= KEXP;
            end
          end
        end
        KEXP: begin
          if (cnt == 4'd10) begin
            keys_ok <= 1'b1;
            fsm     <= INIT;
          end else cnt <= cnt + 4'd1;
        end
        INIT: begin
          st  <= ct ^ rk[10];
          rnd <= 4'd9;
          fsm <= ROUND;
        end
        ROUND: begin
          st  <= imc;
          rnd <= rnd - 4'd1;
          if (rnd == 4'd1) fsm <= FINAL;
        end
        FINAL: begin
          plaintext <= isb ^ rk[0];
          out_valid <= 1'b1;
          fsm       <= HOLD;
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
            fsm       <= IDLE;
          end
        end
        default: begin
          fsm       <= IDLE;
          in_ready  <= 1'b0;
          busy      <= 1'b0;
          out_valid <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_aes_decrypt_iter.sv
// Directed bench for aes_decrypt_iter. Uses the FIPS-197 vectors, a scoreboard of
// expected plaintexts, and checks latency, backpressure and reset abort.
module tb_aes_decrypt_iter;
  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid, in_ready, out_valid, out_ready, busy;
  logic [127:0] data_in, key, plaintext;

  int checks = 0;
  int errors = 0;
  logic [127:0] sb [$];

  localparam logic [127:0] K_C1  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT_C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT_C1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] K_B   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;

  aes_decrypt_iter dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .data_in(data_in), .key(key), .out_valid(out_valid), .out_ready(out_ready),
    .plaintext(plaintext), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // The DUT acts on the falling edge, so the bench samples and drives 1ns after it.
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic accept_op(input logic [127:0] c, input logic [127:0] k, input logic [127:0] exp);
    chk("in_ready_before_accept", in_ready, 1'b1);
    data_in  = c;
    key      = k;
    in_valid = 1'b1;
    sb.push_back(exp);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic run_op(input string tag, input logic [127:0] c, input logic [127:0] k,
                        input logic [127:0] exp, input int exp_lat, input int bp, input bit noise);
    int lat;
    logic [127:0] want;
    accept_op(c, k, exp);
    chk({tag, "_busy"}, busy, 1'b1);
    lat = 0;
    while (!out_valid && lat < 60) begin
      if (noise) begin
        in_valid = 1'($urandom_range(0, 1));
        data_in  = {$urandom, $urandom, $urandom, $urandom};
        key      = {$urandom, $urandom, $urandom, $urandom};
      end
      tick();
      lat++;
    end
    in_valid = 1'b0;
    chk({tag, "_out_valid"}, out_valid, 1'b1);
    chk({tag, "_latency"}, 128'(lat), 128'(exp_lat));
    want = (sb.size() > 0) ? sb.pop_front() : '0;
    chk({tag, "_plaintext"}, plaintext, want);
    chk({tag, "_in_ready_hold"}, in_ready, 1'b0);
    for (int i = 0; i < bp; i++) begin
      tick();
      chk({tag, "_bp_valid"}, out_valid, 1'b1);
      chk({tag, "_bp_stable"}, plaintext, want);
      chk({tag, "_bp_in_ready"}, in_ready, 1'b0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "_released"}, out_valid, 1'b0);
    chk({tag, "_idle_ready"}, in_ready, 1'b1);
    chk({tag, "_idle_busy"}, busy, 1'b0);
    chk({tag, "_pt_kept"}, plaintext, want);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; data_in = '0; key = '0;
    tick(); tick();
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_plaintext", plaintext, 128'h0);
    reset = 1'b0;
    tick();
    chk("post_rst_in_ready", in_ready, 1'b1);

    run_op("c1", CT_C1, K_C1, PT_C1, 21, 0, 1'b0);
    run_op("b_newkey", CT_B, K_B, PT_B, 21, 0, 1'b0);
    run_op("b_reuse_bp", CT_B, K_B, PT_B, 11, 5, 1'b0);
    run_op("b_noise", CT_B, K_B, PT_B, 11, 0, 1'b1);

    // Start a C.1 operation so that it performs key expansion, then abort it partway through.
    accept_op(CT_C1, K_C1, PT_C1);
    repeat (4) tick();
    chk("abort_busy_before", busy, 1'b1);
    #2 reset = 1'b1;
    #1;
    chk("abort_async_busy", busy, 1'b0);
    chk("abort_async_pt", plaintext, 128'h0);
    chk("abort_async_valid", out_valid, 1'b0);
    void'(sb.pop_back());
    tick(); tick();
    reset = 1'b0;
    tick();
    chk("abort_in_ready", in_ready, 1'b1);
    chk("abort_no_valid", out_valid, 1'b0);

    // rk[0] still holds the C.1 key. The operation must still perform key expansion.
    run_op("c1_after_abort", CT_C1, K_C1, PT_C1, 21, 0, 1'b0);
    run_op("c1_reuse", CT_C1, K_C1, PT_C1, 11, 0, 1'b0);
    run_op("b_change", CT_B, K_B, PT_B, 21, 2, 1'b0);

    chk("scoreboard_empty", 128'(sb.size()), 128'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
